// File: rtl/fan_pi_ctrl_mc_if.sv
// -----------------------------------------------------------------------------
// fan_pi_ctrl_mc_if
//   ADC sample handshake between the sample sequencer (master) and the fan
//   controller (slave). A sample transfers on a clock where adc_valid and
//   adc_ready are both high.
//   adc_valid  master->slave  sample valid
//   adc_ch     master->slave  sample channel (CH_W bits)
//   adc_value  master->slave  unsigned sample (ADC_W bits)
//   adc_ready  slave->master  controller idle, sample will be taken
// -----------------------------------------------------------------------------
interface fan_pi_ctrl_mc_if #(
  parameter int CH_W  = 2,
  parameter int ADC_W = 6
);
  logic             adc_valid;
  logic [CH_W-1:0]  adc_ch;
  logic [ADC_W-1:0] adc_value;
  logic             adc_ready;

  modport master (output adc_valid, adc_ch, adc_value, input adc_ready);
  modport slave  (input adc_valid, adc_ch, adc_value, output adc_ready);
endinterface

// File: rtl/fan_pi_ctrl_mc.sv
// -----------------------------------------------------------------------------
// fan_pi_ctrl_mc
//   N-channel fan controller. One time-multiplexed incremental PI engine
//   (y += b_now*e[k] + b_prev*e[k-1]) updates one channel per accepted ADC
//   sample; each channel drives a PWM output from a shared period counter.
//   Ports:
//     clk_i, rst_i           clock, synchronous active-high reset
//     clk_en_i               PWM counter advance enable
//     cfg_we_i/ch_i/set_i    per-channel setpoint write
//     adc_if (slave)         sample handshake, ready = engine idle
//     b_now_i, b_prev_i      signed Q(COEF_W-FRAC_W).FRAC_W coefficients
//     pwm_period_i/min_i     PWM period and minimum non-zero duty
//     upd_done_o/upd_ch_o    one-cycle pulse + channel of completed update
//     pwm_o                  PWM outputs, one bit per channel
// -----------------------------------------------------------------------------
module fan_pi_ctrl_mc #(
  parameter int NUM_CH = 4,
  parameter int ADC_W  = 6,
  parameter int FRAC_W = 6,
  parameter int COEF_W = 10,
  parameter int PWM_W  = 7,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clk_en_i,
  input  logic                     cfg_we_i,
  input  logic [CH_W-1:0]          cfg_ch_i,
  input  logic [ADC_W-1:0]         cfg_set_i,
  fan_pi_ctrl_mc_if.slave          adc_if,
  input  logic signed [COEF_W-1:0] b_now_i,
  input  logic signed [COEF_W-1:0] b_prev_i,
  input  logic [PWM_W-1:0]         pwm_period_i,
  input  logic [PWM_W-1:0]         pwm_min_i,
  output logic                     upd_done_o,
  output logic [CH_W-1:0]          upd_ch_o,
  output logic [NUM_CH-1:0]        pwm_o
);

  localparam int E_W    = ADC_W + 1;           // signed error
  localparam int PROD_W = COEF_W + ADC_W + 1;  // signed product
  localparam int ACC_W  = PROD_W + 1;          // two products summed
  localparam int SUM_W  = ACC_W + 1;           // y + acc
  localparam int Y_W    = ADC_W + FRAC_W;      // unsigned controller state
  localparam logic signed [SUM_W-1:0] Y_MAX_S = SUM_W'((1 << Y_W) - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL0, S_MUL1, S_WB} state_e;

  state_e                    state_q, state_d;
  logic [CH_W-1:0]           ch_q;
  logic signed [E_W-1:0]     e_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic [ADC_W-1:0]          set_q       [NUM_CH];
  logic [Y_W-1:0]            y_q         [NUM_CH];
  logic signed [E_W-1:0]     e_prev_q    [NUM_CH];
  logic [ADC_W-1:0]          duty_next_q [NUM_CH];
  logic [PWM_W-1:0]          duty_q      [NUM_CH];
  logic [PWM_W-1:0]          cnt_q;
  logic [NUM_CH-1:0]         pwm_q;
  logic                      upd_done_q;
  logic [CH_W-1:0]           upd_ch_q;

  logic                      accept, adc_ch_ok, cfg_ch_ok;
  logic signed [E_W-1:0]     e_in;
  logic signed [PROD_W-1:0]  prod_now, prod_prev;
  logic signed [SUM_W-1:0]   sum_s;
  logic [Y_W-1:0]            clamp_y;
  logic [PWM_W-1:0]          load_val [NUM_CH];
  logic [PWM_W-1:0]          duty_cur [NUM_CH];

  // Channel range checks collapse to constants when NUM_CH fills the index.
  if ((1 << CH_W) == NUM_CH) begin : g_ch_full
    assign adc_ch_ok = 1'b1;
    assign cfg_ch_ok = 1'b1;
  end else begin : g_ch_part
    assign adc_ch_ok = (adc_if.adc_ch < CH_W'(NUM_CH));
    assign cfg_ch_ok = (cfg_ch_i < CH_W'(NUM_CH));
  end

  assign adc_if.adc_ready = (state_q == S_IDLE);
  assign accept           = adc_if.adc_valid && adc_if.adc_ready;
  assign upd_done_o       = upd_done_q;
  assign upd_ch_o         = upd_ch_q;
  assign pwm_o            = pwm_q;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept && adc_ch_ok) state_d = S_MUL0;
      S_MUL0:  state_d = S_MUL1;
      S_MUL1:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    // Setpoint is read before any same-cycle cfg write lands.
    e_in      = $signed({1'b0, set_q[adc_if.adc_ch]}) - $signed({1'b0, adc_if.adc_value});
    prod_now  = PROD_W'(b_now_i) * PROD_W'(e_q);
    prod_prev = PROD_W'(b_prev_i) * PROD_W'(e_prev_q[ch_q]);
    sum_s     = SUM_W'($signed({1'b0, y_q[ch_q]})) + SUM_W'(acc_q);
    // Anti-windup: state never leaves the range the duty can express.
    if (sum_s[SUM_W-1])        clamp_y = '0;
    else if (sum_s > Y_MAX_S)  clamp_y = '1;
    else                       clamp_y = sum_s[Y_W-1:0];
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      // Zero duty stays off; any non-zero duty is lifted to the start floor.
      if (duty_next_q[c] == '0)
        load_val[c] = '0;
      else if (PWM_W'(duty_next_q[c]) > pwm_min_i)
        load_val[c] = PWM_W'(duty_next_q[c]);
      else
        load_val[c] = pwm_min_i;
      // Reload only at cnt==0 so a period is never cut short or stretched.
      duty_cur[c] = (cnt_q == '0) ? load_val[c] : duty_q[c];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ch_q       <= '0;
      e_q        <= '0;
      acc_q      <= '0;
      upd_done_q <= 1'b0;
      upd_ch_q   <= '0;
      // NOTE: these per-channel arrays are plain flops, not RAM, so they can
      // and must be cleared: the controller restarts from all-zero state.
      for (int c = 0; c < NUM_CH; c++) begin
        set_q[c]       <= '0;
        y_q[c]         <= '0;
        e_prev_q[c]    <= '0;
        duty_next_q[c] <= '0;
      end
    end else begin
      upd_done_q <= 1'b0;
      if (cfg_we_i && cfg_ch_ok) set_q[cfg_ch_i] <= cfg_set_i;
      unique case (state_q)
        S_IDLE: if (accept && adc_ch_ok) begin
          ch_q <= adc_if.adc_ch;
          e_q  <= e_in;
        end
        S_MUL0: acc_q <= ACC_W'(prod_now);
        S_MUL1: acc_q <= acc_q + ACC_W'(prod_prev);
        S_WB: begin
          y_q[ch_q]         <= clamp_y;
          e_prev_q[ch_q]    <= e_q;
          duty_next_q[ch_q] <= clamp_y[Y_W-1:FRAC_W];
          upd_done_q        <= 1'b1;
          upd_ch_q          <= ch_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      pwm_q <= '0;
      for (int c = 0; c < NUM_CH; c++) duty_q[c] <= '0;
    end else if (clk_en_i) begin
      if (pwm_period_i == '0)                      cnt_q <= '0;
      else if (cnt_q >= pwm_period_i - PWM_W'(1))  cnt_q <= '0;
      else                                         cnt_q <= cnt_q + PWM_W'(1);
      for (int c = 0; c < NUM_CH; c++) begin
        if (cnt_q == '0) duty_q[c] <= load_val[c];
        pwm_q[c] <= (pwm_period_i != '0) && (cnt_q < duty_cur[c]);
      end
    end
  end

endmodule

// File: tb/tb_fan_pi_ctrl_mc.sv
// -----------------------------------------------------------------------------
// tb_fan_pi_ctrl_mc
//   Directed bench for fan_pi_ctrl_mc. Stimulus tasks push the expected
//   update channel into a scoreboard; a negedge monitor pops it when
//   upd_done_o pulses and checks channel and accept-to-done latency.
//   PWM widths are counted from a per-cycle history of pwm_o and compared
//   with hand-computed duties. A second 3-channel instance exercises the
//   out-of-range sample channel.
// -----------------------------------------------------------------------------
module tb_fan_pi_ctrl_mc;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int ADC_W  = 6;
  localparam int PERIOD = 76;
  localparam int HIST_N = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst, clk_en, cfg_we;
  logic [CH_W-1:0]     cfg_ch;
  logic [ADC_W-1:0]    cfg_set;
  logic signed [9:0]   b_now, b_prev;
  logic [6:0]          period, pmin;
  logic                upd_done, b_done;
  logic [CH_W-1:0]     upd_ch, b_ch;
  logic [NUM_CH-1:0]   pwm;
  logic [2:0]          b_pwm;

  fan_pi_ctrl_mc_if #(.CH_W(CH_W), .ADC_W(ADC_W)) adc_if ();
  fan_pi_ctrl_mc_if #(.CH_W(CH_W), .ADC_W(ADC_W)) adcb_if ();

  fan_pi_ctrl_mc #(.NUM_CH(NUM_CH)) dut (
    .clk_i(clk), .rst_i(rst), .clk_en_i(clk_en),
    .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch), .cfg_set_i(cfg_set),
    .adc_if(adc_if.slave), .b_now_i(b_now), .b_prev_i(b_prev),
    .pwm_period_i(period), .pwm_min_i(pmin),
    .upd_done_o(upd_done), .upd_ch_o(upd_ch), .pwm_o(pwm)
  );

  fan_pi_ctrl_mc #(.NUM_CH(3)) dut_b (
    .clk_i(clk), .rst_i(rst), .clk_en_i(clk_en),
    .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch), .cfg_set_i(cfg_set),
    .adc_if(adcb_if.slave), .b_now_i(b_now), .b_prev_i(b_prev),
    .pwm_period_i(period), .pwm_min_i(pmin),
    .upd_done_o(b_done), .upd_ch_o(b_ch), .pwm_o(b_pwm)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int exp_q[$];     // expected upd_ch per issued sample
  int pend_acc[$];  // accept cycle of each in-flight update
  int acc_log[$];   // every handshake cycle
  int meas[NUM_CH];
  logic [NUM_CH-1:0] hist [HIST_N];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (cyc < HIST_N) hist[cyc] = pwm;

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (upd_done) begin
        if (exp_q.size() == 0 || pend_acc.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          check("upd_ch", upd_ch, exp_q.pop_front());
          check("done_latency", cyc - pend_acc.pop_front(), 4);
        end
      end
      if (adc_if.adc_valid && adc_if.adc_ready) begin
        acc_log.push_back(cyc);
        pend_acc.push_back(cyc);
      end
    end
  end

  task automatic wr_set(input int ch, input int val);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_set = ADC_W'(val);
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic send(input int ch, input int val);
    bit got = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(ch);
    adc_if.adc_valid = 1'b1; adc_if.adc_ch = CH_W'(ch); adc_if.adc_value = ADC_W'(val);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (adc_if.adc_ready) begin got = 1'b1; break; end
    end
    if (!got) check("send_timeout", 0, 1);
    @(posedge clk); #1;
    adc_if.adc_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) check("wait_idle_timeout", exp_q.size(), 0);
  endtask

  function automatic int cnt_hi(input int ch, input int a, input int b);
    int n = 0;
    for (int i = a; i < b; i++) if (i >= 0 && i < HIST_N && hist[i][ch]) n++;
    return n;
  endfunction

  // Settle past any pending reload, then count highs over one full period.
  task automatic measure();
    int s;
    repeat (PERIOD + 4) @(negedge clk);
    s = cyc;
    repeat (PERIOD) @(negedge clk);
    #1;
    for (int c = 0; c < NUM_CH; c++) meas[c] = cnt_hi(c, s, s + PERIOD);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int m, k, busy, bad;
    bit p, found;
    rst = 1'b1; clk_en = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_set = '0;
    b_now = 10'sd9; b_prev = -10'sd8; period = 7'd76; pmin = 7'd12;
    adc_if.adc_valid = 1'b0; adc_if.adc_ch = '0; adc_if.adc_value = '0;
    adcb_if.adc_valid = 1'b0; adcb_if.adc_ch = '0; adcb_if.adc_value = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_ready", adc_if.adc_ready, 1);
    check("rst_done", upd_done, 0);
    check("rst_upd_ch", upd_ch, 0);
    check("rst_pwm", pwm, 0);

    // set0=40, adc=20: y=180, duty_next=2 -> floor 12
    wr_set(0, 40);
    send(0, 20);
    wait_idle();
    measure();
    check("ch0_floor_width", meas[0], 12);

    // Second identical sample: y=200 -> duty 3, visible with floor 1
    send(0, 20);
    wait_idle();
    @(posedge clk); #1 pmin = 7'd1;
    measure();
    check("ch0_y200_width", meas[0], 3);
    @(posedge clk); #1 pmin = 7'd12;

    // Negative clamp: set2=0, adc=63 -> y stays 0, output off despite floor
    wr_set(2, 0);
    send(2, 63);
    wait_idle();
    measure();
    check("ch2_neg_clamp", meas[2], 0);
    check("ch0_unchanged", meas[0], 12);

    // Saturation: b_now=511, e=63 -> y=4095, duty 63
    @(posedge clk); #1 b_now = 10'sd511;
    wr_set(1, 63);
    send(1, 0);
    wait_idle();
    measure();
    check("ch1_sat_width", meas[1], 63);
    send(1, 0);
    wait_idle();
    // y must sit exactly at 4095: b_now=1.0, e=-1 -> 4031 -> duty 62
    @(posedge clk); #1 b_now = 10'sd64; b_prev = 10'sd0;
    wr_set(1, 0);
    send(1, 1);
    wait_idle();
    measure();
    check("ch1_unwind_width", meas[1], 62);

    // Duty reload: ch0 update lands mid-period (e=40 -> y=2760 -> duty 43)
    wr_set(0, 63);
    found = 1'b0; p = pwm[1]; m = 0;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      @(negedge clk);
      if (pwm[1] && !p) begin found = 1'b1; m = cyc; break; end
      p = pwm[1];
    end
    check("period_marker_found", found, 1);
    while (cyc < m + 19) @(negedge clk);
    send(0, 23);
    wait_idle();
    while (cyc < m + 2 * PERIOD + 1) @(negedge clk);
    #1;
    check("reload_old_width", cnt_hi(0, m, m + 20), 12);
    check("reload_no_midperiod", cnt_hi(0, m + 20, m + PERIOD), 0);
    check("reload_new_width", cnt_hi(0, m + PERIOD, m + 2 * PERIOD), 43);
    @(posedge clk); #1 b_now = 10'sd9; b_prev = -10'sd8;

    // Handshake: valid held over two ch3 samples
    @(posedge clk); #1;
    exp_q.push_back(3); exp_q.push_back(3);
    adc_if.adc_valid = 1'b1; adc_if.adc_ch = 2'd3; adc_if.adc_value = '0;
    k = 0; busy = 0;
    for (int i = 0; i < 30 && k < 2; i++) begin
      @(negedge clk);
      if (adc_if.adc_ready) k++;
      else if (k == 1) busy++;
    end
    @(posedge clk); #1 adc_if.adc_valid = 1'b0;
    check("hs_accepts", k, 2);
    check("hs_ready_low", busy, 3);
    check("hs_accept_gap", acc_log[$] - acc_log[$-1], 4);
    wait_idle();

    // Out-of-range channel on a 3-channel instance: accepted and dropped
    @(posedge clk); #1;
    adcb_if.adc_valid = 1'b1; adcb_if.adc_ch = 2'd3; adcb_if.adc_value = '0;
    @(negedge clk);
    check("inv_ch_ready", adcb_if.adc_ready, 1);
    @(posedge clk); #1 adcb_if.adc_valid = 1'b0;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (!adcb_if.adc_ready || b_done) bad++;
    end
    check("inv_ch_no_update", bad, 0);

    // Reset during MUL1 of a ch3 update
    wr_set(3, 63);
    @(posedge clk); #1;
    exp_q.push_back(3);
    adc_if.adc_valid = 1'b1; adc_if.adc_ch = 2'd3; adc_if.adc_value = '0;
    @(posedge clk); #1 adc_if.adc_valid = 1'b0;   // accepted, now MUL0
    @(posedge clk); #1 rst = 1'b1;                // now MUL1
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    pend_acc.delete();
    @(negedge clk);
    check("midrst_ready", adc_if.adc_ready, 1);
    check("midrst_pwm", pwm, 0);
    check("midrst_done", upd_done, 0);

    // Fresh state: set3=40, adc=20 -> y=180 -> duty 2 with floor 1
    @(posedge clk); #1 pmin = 7'd1;
    wr_set(3, 40);
    send(3, 20);
    wait_idle();
    measure();
    check("post_rst_ch3_width", meas[3], 2);
    check("post_rst_ch0_off", meas[0], 0);
    check("post_rst_ch1_off", meas[1], 0);

    repeat (8) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
